srt4_pa_regfile: RTL

//  Parametrised partial-remainder/quotient register file for the radix-4 SRT divider.

---
 rtl/srt4_pa_regfile.sv | 130 +++++++++++++
 1 files changed

// File: rtl/srt4_pa_regfile.sv
// P / A / A' register file for the radix-4 SRT divider, with a normalisation
// shift counter, quotient correction (A <= A - A') and a sticky error flag.
module srt4_pa_regfile #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [2:0]       op,
    input  logic [2:0]       qdig,
    input  logic [WIDTH:0]   din_p,
    input  logic [WIDTH-1:0] din_a,
    output logic [WIDTH:0]   p_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] ap_q,
    output logic [1:0]       out_bits,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             cnt_zero,
    output logic             err
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_LOAD   = 3'b001,
        OP_NORM   = 3'b010,
        OP_STEP   = 3'b011,
        OP_LOADP  = 3'b100,
        OP_DENORM = 3'b101,
        OP_LOADA  = 3'b110,
        OP_CORR   = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_ap;
    logic [1:0]       r_out_bits;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [1:0] w_dig_a;
    logic [1:0] w_dig_ap;
    logic       w_dig_bad;

    // Signed digit splits into a positive bit-pair for A and a negative one for A'.
    always_comb begin
        w_dig_a   = 2'b00;
        w_dig_ap  = 2'b00;
        w_dig_bad = 1'b0;
        case (qdig)
            3'b001:  w_dig_a   = 2'b01;
            3'b010:  w_dig_a   = 2'b10;
            3'b111:  w_dig_ap  = 2'b01;
            3'b110:  w_dig_ap  = 2'b10;
            3'b000:  w_dig_bad = 1'b0;
            default: w_dig_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_p        <= '0;
            r_a        <= '0;
            r_ap       <= '0;
            r_out_bits <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (op_e'(op))
                OP_LOAD: begin
                    r_p        <= '0;
                    r_a        <= din_a;
                    r_ap       <= '0;
                    r_cnt      <= '0;
                    r_out_bits <= '0;
                    r_err      <= 1'b0;
                end
                OP_NORM: begin
                    if (r_cnt == CNT_MAX) begin
                        r_err <= 1'b1;
                    end else begin
                        r_p        <= {r_p[WIDTH-1:0], r_a[WIDTH-1]};
                        r_a        <= {r_a[WIDTH-2:0], 1'b0};
                        r_out_bits <= {1'b0, r_p[WIDTH]};
                        r_cnt      <= r_cnt + CNT_W'(1);
                    end
                end
                OP_STEP: begin
                    r_p        <= {r_p[WIDTH-2:0], r_a[WIDTH-1:WIDTH-2]};
                    r_a        <= {r_a[WIDTH-3:0], w_dig_a};
                    r_ap       <= {r_ap[WIDTH-3:0], w_dig_ap};
                    r_out_bits <= r_p[WIDTH:WIDTH-1];
                    if (w_dig_bad) begin
                        r_err <= 1'b1;
                    end
                end
                OP_LOADP: begin
                    r_p <= din_p;
                end
                OP_DENORM: begin
                    if (r_cnt == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_p   <= {1'b0, r_p[WIDTH:1]};
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                OP_LOADA: begin
                    r_a <= din_a;
                end
                OP_CORR: begin
                    r_a  <= r_a - r_ap;
                    r_ap <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign p_q       = r_p;
    assign a_q       = r_a;
    assign ap_q      = r_ap;
    assign out_bits  = r_out_bits;
    assign shift_cnt = r_cnt;
    assign cnt_zero  = (r_cnt == '0);
    assign err       = r_err;

endmodule
